// File: rtl/riscv_enc_pkg.sv
// Shared types and constants for the RISC-V instruction encoder.
// IMM_RANGE_CHECK_EN (optional define) enables immediate range checking in instr_pack.
package riscv_enc_pkg;

  typedef enum logic [2:0] {
    FmtR = 3'd0,
    FmtI = 3'd1,
    FmtS = 3'd2,
    FmtB = 3'd3,
    FmtU = 3'd4,
    FmtJ = 3'd5
  } fmt_e;

  localparam logic [6:0] OpcOp     = 7'h33;
  localparam logic [6:0] OpcOpImm  = 7'h13;
  localparam logic [6:0] OpcLoad   = 7'h03;
  localparam logic [6:0] OpcStore  = 7'h23;
  localparam logic [6:0] OpcBranch = 7'h63;
  localparam logic [6:0] OpcJal    = 7'h6f;
  localparam logic [6:0] OpcJalr   = 7'h67;
  localparam logic [6:0] OpcLui    = 7'h37;
  localparam logic [6:0] OpcAuipc  = 7'h17;

  localparam logic [31:0] InstrNop = 32'h0000_0013;

  // True when v is the sign extension of its low w bits.
  function automatic logic fits_signed(logic [31:0] v, int unsigned w);
    logic [31:0] s;
    s = $signed(v) >>> (w - 1);
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packing of decoded fields into a 32-bit RISC-V word plus error flag.
// IMM_RANGE_CHECK_EN adds immediate range checking to the error flag.
module instr_pack
  import riscv_enc_pkg::*;
(
  input  logic [2:0]  fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] instr_o,
  output logic        err_o
);

  logic illegal;

  always_comb begin
    instr_o = InstrNop;
    illegal = 1'b0;
    case (fmt_i)
      FmtR: instr_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      FmtI: instr_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
      FmtS: instr_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
      FmtB: instr_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11],
                       opcode_i};
      FmtU: instr_o = {imm_i[31:12], rd_i, opcode_i};
      FmtJ: instr_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
      default: begin
        instr_o = InstrNop;
        illegal = 1'b1;
      end
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  logic imm_err;

  always_comb begin
    imm_err = 1'b0;
    case (fmt_i)
      FmtI, FmtS: imm_err = !fits_signed(imm_i, 12);
      FmtB:       imm_err = !fits_signed(imm_i, 13) || imm_i[0];
      FmtJ:       imm_err = !fits_signed(imm_i, 21) || imm_i[0];
      FmtU:       imm_err = |imm_i[11:0];
      default:    imm_err = 1'b0;
    endcase
  end

  assign err_o = illegal | imm_err;
`else
  assign err_o = illegal;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Streams encoded instruction words with byte addresses through a registered output plus skid.
// IMM_RANGE_CHECK_EN (optional define) is honoured by the instr_pack sub-module.
module instr_encoder
  import riscv_enc_pkg::*;
#(
  parameter int unsigned        ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [2:0]        in_funct3,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_load_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [15:0]       err_count
);

  logic [31:0]       pack_instr;
  logic              pack_err;
  logic [ADDR_W-1:0] word_addr;
  logic              accept;
  logic              out_free;

  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_instr_q, out_instr_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              out_err_q, out_err_d;
  logic              skid_valid_q, skid_valid_d;
  logic [31:0]       skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0] skid_addr_q, skid_addr_d;
  logic              skid_err_q, skid_err_d;
  logic [15:0]       err_count_q, err_count_d;
  logic              issue_err;

  instr_pack u_pack (
    .fmt_i    (in_fmt),
    .opcode_i (in_opcode),
    .rd_i     (in_rd),
    .funct3_i (in_funct3),
    .rs1_i    (in_rs1),
    .rs2_i    (in_rs2),
    .funct7_i (in_funct7),
    .imm_i    (in_imm),
    .instr_o  (pack_instr),
    .err_o    (pack_err)
  );

  // The skid only fills while the output is stalled, so it alone gates input acceptance.
  assign in_ready  = !skid_valid_q && !rst;
  assign accept    = in_valid && in_ready;
  assign out_free  = !out_valid_q || out_ready;
  assign word_addr = addr_load ? addr_load_val : cnt_q;

  always_comb begin
    cnt_d        = cnt_q;
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_addr_d   = out_addr_q;
    out_err_d    = out_err_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_addr_d  = skid_addr_q;
    skid_err_d   = skid_err_q;
    err_count_d  = err_count_q;
    issue_err    = 1'b0;

    if (accept) begin
      cnt_d = word_addr + ADDR_W'(4);
    end else if (addr_load) begin
      cnt_d = addr_load_val;
    end

    if (out_free) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_instr_d  = skid_instr_q;
        out_addr_d   = skid_addr_q;
        out_err_d    = skid_err_q;
        skid_valid_d = 1'b0;
        issue_err    = skid_err_q;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_instr_d = pack_instr;
        out_addr_d  = word_addr;
        out_err_d   = pack_err;
        issue_err   = pack_err;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_instr_d = pack_instr;
      skid_addr_d  = word_addr;
      skid_err_d   = pack_err;
    end

    // Errors are counted as words enter the output register, not when parked in the skid.
    if (issue_err && (err_count_q != 16'hffff)) begin
      err_count_d = err_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= RESET_ADDR;
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_addr_q   <= '0;
      out_err_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_addr_q  <= '0;
      skid_err_q   <= 1'b0;
      err_count_q  <= '0;
    end else begin
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_addr_q   <= out_addr_d;
      out_err_q    <= out_err_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_addr_q  <= skid_addr_d;
      skid_err_q   <= skid_err_d;
      err_count_q  <= err_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_addr  = out_addr_q;
  assign out_err   = out_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed cases plus randomized traffic vs. a reference model.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        addr_load;
  logic [31:0] addr_load_val;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;
  logic [15:0] err_count;

  always #5 clk = ~clk;

  instr_encoder #(
    .ADDR_W     (32),
    .RESET_ADDR (32'h0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_fmt        (in_fmt),
    .in_opcode     (in_opcode),
    .in_rd         (in_rd),
    .in_funct3     (in_funct3),
    .in_rs1        (in_rs1),
    .in_rs2        (in_rs2),
    .in_funct7     (in_funct7),
    .in_imm        (in_imm),
    .addr_load     (addr_load),
    .addr_load_val (addr_load_val),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_addr      (out_addr),
    .out_err       (out_err),
    .err_count     (err_count)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_instr_q[$];
  logic [31:0] exp_addr_q[$];
  logic        exp_err_q[$];
  logic [31:0] m_cnt;
  int unsigned m_errs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Which immediate bit lands in instruction bit i for a given format (-1: field bit).
  function automatic int imm_src(int fmt, int i);
    case (fmt)
      1: return (i >= 20) ? i - 20 : -1;
      2: return (i >= 25) ? i - 20 : ((i >= 7 && i <= 11) ? i - 7 : -1);
      3: begin
        if (i == 31) return 12;
        if (i >= 25) return i - 20;
        if (i >= 8 && i <= 11) return i - 7;
        if (i == 7) return 11;
        return -1;
      end
      4: return (i >= 12) ? i : -1;
      5: begin
        if (i == 31) return 20;
        if (i >= 21) return i - 20;
        if (i == 20) return 11;
        if (i >= 12 && i <= 19) return i;
        return -1;
      end
      default: return -1;
    endcase
  endfunction

  function automatic logic [31:0] model_instr(int fmt, logic [6:0] op, logic [4:0] rd,
                                              logic [2:0] f3, logic [4:0] rs1, logic [4:0] rs2,
                                              logic [6:0] f7, logic [31:0] imm);
    logic [31:0] w;
    int s;
    if (fmt > 5) return 32'h0000_0013;
    w = 32'(op);
    if (fmt == 0 || fmt == 1 || fmt == 4 || fmt == 5) w = w | (32'(rd) << 7);
    if (fmt <= 3) w = w | (32'(f3) << 12) | (32'(rs1) << 15);
    if (fmt == 0 || fmt == 2 || fmt == 3) w = w | (32'(rs2) << 20);
    if (fmt == 0) w = w | (32'(f7) << 25);
    for (int i = 7; i < 32; i++) begin
      s = imm_src(fmt, i);
      if (s >= 0) w[i] = imm[s];
    end
    return w;
  endfunction

  function automatic logic model_err(int fmt, logic [31:0] imm);
    int si;
    if (fmt > 5) return 1'b1;
    si = $signed(imm);
`ifdef IMM_RANGE_CHECK_EN
    case (fmt)
      1, 2: return (si < -2048) || (si > 2047);
      3: return (si < -4096) || (si > 4095) || (imm[0] == 1'b1);
      4: return (imm & 32'hfff) != 0;
      5: return (si < -(1 << 20)) || (si > (1 << 20) - 1) || (imm[0] == 1'b1);
      default: return 1'b0;
    endcase
`else
    return (si == 0) && 1'b0;
`endif
  endfunction

  // One clock: handshakes observed at the falling edge, inputs change #1 after the rising edge.
  task automatic cycle();
    logic [31:0] a;
    @(negedge clk);
    if (!rst) begin
      chk("in_ready", 32'(in_ready), 32'(exp_instr_q.size() < 2));
      chk("out_valid", 32'(out_valid), 32'(exp_instr_q.size() > 0));
      if (out_valid && out_ready && exp_instr_q.size() > 0) begin
        chk("sb_instr", out_instr, exp_instr_q.pop_front());
        chk("sb_addr", out_addr, exp_addr_q.pop_front());
        chk("sb_err", 32'(out_err), 32'(exp_err_q.pop_front()));
      end
      if (in_valid && in_ready) begin
        a = addr_load ? addr_load_val : m_cnt;
        exp_instr_q.push_back(model_instr(int'(in_fmt), in_opcode, in_rd, in_funct3, in_rs1,
                                          in_rs2, in_funct7, in_imm));
        exp_addr_q.push_back(a);
        exp_err_q.push_back(model_err(int'(in_fmt), in_imm));
        if (model_err(int'(in_fmt), in_imm)) m_errs++;
        m_cnt = a + 32'd4;
      end else if (addr_load) begin
        m_cnt = addr_load_val;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    exp_instr_q.delete();
    exp_addr_q.delete();
    exp_err_q.delete();
    m_cnt  = 32'h0;
    m_errs = 0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    addr_load = 1'b0;
    model_clear();
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic set_word(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                          input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = f; in_opcode = op; in_rd = rd; in_funct3 = f3;
    in_rs1 = rs1; in_rs2 = rs2; in_funct7 = f7; in_imm = imm;
  endtask

  task automatic rand_word();
    logic [31:0] r;
    logic [31:0] imm;
    r = $urandom;
    case ($urandom_range(0, 4))
      0: imm = r;
      1: imm = {{20{r[11]}}, r[11:0]};
      2: imm = {{19{r[12]}}, r[12:1], 1'b0};
      3: imm = {{11{r[20]}}, r[20:1], 1'b0};
      default: imm = {r[31:12], 12'h0};
    endcase
    set_word(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 3'($urandom),
             5'($urandom), 5'($urandom), 7'($urandom), imm);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; addr_load = 1'b0; addr_load_val = '0;
    set_word(3'd0, 7'h0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
    model_clear();

    // Reset state.
    cycle();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", out_addr, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    rst = 1'b0;

    // addi x1,x0,5
    set_word(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("addi_valid", 32'(out_valid), 32'd1);
    chk("addi_instr", out_instr, 32'h0050_0093);
    chk("addi_addr", out_addr, 32'h0);
    chk("addi_err", 32'(out_err), 32'd0);
    cycle();

    // beq x1,x2,-4 then jal x0,8
    do_reset();
    set_word(3'd3, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'hffff_fffc);
    in_valid = 1'b1;
    cycle();
    chk("beq_instr", out_instr, 32'hfe20_8ee3);
    chk("beq_addr", out_addr, 32'h0);
    set_word(3'd5, 7'h6f, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd8);
    cycle();
    in_valid = 1'b0;
    chk("jal_instr", out_instr, 32'h0080_006f);
    chk("jal_addr", out_addr, 32'h4);
    cycle();

    // I-format immediate just out of range
    do_reset();
    set_word(3'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
`ifdef IMM_RANGE_CHECK_EN
    chk("imm2048_err", 32'(out_err), 32'd1);
    chk("imm2048_cnt", 32'(err_count), 32'd1);
`else
    chk("imm2048_err", 32'(out_err), 32'd0);
    chk("imm2048_field", 32'(out_instr[31:20]), 32'h800);
    chk("imm2048_cnt", 32'(err_count), 32'd0);
`endif
    cycle();

    // Back-pressure: output + skid fill, then drain in order
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    rand_word();
    cycle();
    rand_word();
    cycle();
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    rand_word();
    cycle();
    chk("bp_hold_addr", out_addr, 32'h0);
    out_ready = 1'b1;
    cycle();
    chk("bp_addr1", out_addr, 32'h4);
    cycle();
    in_valid = 1'b0;
    chk("bp_addr2", out_addr, 32'h8);
    cycle();

    // addr_load coinciding with accept; illegal format
    do_reset();
    addr_load = 1'b1;
    addr_load_val = 32'h100;
    set_word(3'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0);
    in_valid = 1'b1;
    cycle();
    addr_load = 1'b0;
    chk("load_addr", out_addr, 32'h100);
    set_word(3'd7, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'd0);
    cycle();
    in_valid = 1'b0;
    chk("next_addr", out_addr, 32'h104);
    chk("illegal_instr", out_instr, 32'h0000_0013);
    chk("illegal_err", 32'(out_err), 32'd1);
    cycle();

    // Reset while output and skid are both full
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_word(3'd6, 7'h13, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
    cycle();
    cycle();
    chk("full_err_count", 32'(err_count), 32'd1);
    rst = 1'b1;
    in_valid = 1'b0;
    model_clear();
    cycle();
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_err_count", 32'(err_count), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    set_word(3'd1, 7'h13, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'd1);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("postrst_addr", out_addr, 32'h0);
    cycle();

    // Randomized traffic with back-pressure and occasional address loads (incl. wrap)
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rand_word();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      addr_load = ($urandom_range(0, 15) == 0);
      addr_load_val = ($urandom_range(0, 1) == 0) ? 32'hffff_fff8 : ($urandom & 32'hffff_fffc);
      cycle();
    end
    in_valid  = 1'b0;
    addr_load = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 10 && exp_instr_q.size() > 0; k++) cycle();
    chk("drain_empty", 32'(exp_instr_q.size()), 32'd0);
    chk("rand_err_count", 32'(err_count), 32'(m_errs));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
